// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small synchronous byte FIFO.
// The FSM pops one byte per frame and drives the line from a register.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic                     i_Tx_DV,
  input  logic [7:0]               i_Tx_Byte,
  output logic                     o_Tx_Ready,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Active,
  output logic                     o_Tx_Done,
  output logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]           CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FILL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   FILL_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           clk_cnt_q;
  logic [2:0]                 bit_idx_q;
  logic [7:0]                 shift_q;
  logic                       serial_q;
  logic                       active_q;
  logic                       done_q;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic [FIFO_DEPTH_LOG2:0]   count_d;
  logic                       push;
  logic                       pop;

  // Ready depends only on the registered fill, so a pop cannot make room in the same cycle.
  assign o_Tx_Ready   = (count_q != FILL_FULL);
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign pop          = (state_q == IDLE) && (count_q != '0);

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + FILL_ONE;
    end else if (pop && !push) begin
      count_d = count_q - FILL_ONE;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

  // The byte is captured at pop time so later writes can never touch the frame in flight.
  always_ff @(posedge i_sys_clk) begin
    if (pop) shift_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            state_q  <= START;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end else begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          // Done is raised one edge early so the registered pulse lands on the last stop cycle.
          if (clk_cnt_q == CNT_PRE) done_q <= 1'b1;
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            active_q  <= 1'b0;
            state_q   <= CLEANUP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        CLEANUP: begin
          serial_q <= 1'b1;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized bench for uart_tx_buffered, compared every cycle against a frame-position model.
module tb_uart_tx_buffered;

  localparam int C     = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          dv      = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          tx_ready;
  logic          tx_serial;
  logic          tx_active;
  logic          tx_done;
  logic [LOG2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queued bytes, the byte on the line, and cycles elapsed since the start bit fell
  // (-1 = idle, FRAME = the single cleanup cycle after the stop bit).
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .i_sys_clk   (clk),
    .i_rst       (rst),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (byte_in),
    .o_Tx_Ready  (tx_ready),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done),
    .o_Fifo_Count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    if (pos < 0 || pos >= 9 * C) return 1'b1;
    if (pos < C) return 1'b0;
    return cur[(pos - C) / C];
  endfunction

  function automatic void model_reset();
    mq.delete();
    pos = -1;
  endfunction

  function automatic void model_edge(input logic wdv, input logic [7:0] wb);
    int  sz  = mq.size();
    bit  acc = wdv && (sz < DEPTH);
    if (pos == -1) begin
      if (sz != 0) begin
        cur = mq.pop_front();
        pos = 0;
      end
    end else if (pos == FRAME) begin
      pos = -1;
    end else begin
      pos++;
    end
    if (acc) mq.push_back(wb);
  endfunction

  task automatic compare_all();
    check("serial", 32'(tx_serial),  32'(exp_line()));
    check("active", 32'(tx_active),  32'(pos >= 0 && pos < FRAME));
    check("done",   32'(tx_done),    32'(pos == FRAME - 1));
    check("count",  32'(fifo_count), 32'(mq.size()));
    check("ready",  32'(tx_ready),   32'(mq.size() < DEPTH));
  endtask

  // Called just after a falling edge: drive inputs, advance one clock, then compare.
  task automatic step(input logic wdv, input logic [7:0] wb);
    dv      = wdv;
    byte_in = wb;
    @(posedge clk);
    model_edge(wdv, wb);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pos != -1 || mq.size() != 0) && n < 1000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check(tag, 32'(pos == -1 && mq.size() == 0), 32'd1);
    repeat (3) step(1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    repeat (100) step(1'b0, 8'h00);
    check("idle_serial", 32'(tx_serial),  32'd1);
    check("idle_ready",  32'(tx_ready),   32'd1);
    check("idle_active", 32'(tx_active),  32'd0);
    check("idle_done",   32'(tx_done),    32'd0);
    check("idle_count",  32'(fifo_count), 32'd0);

    step(1'b1, 8'hA5);
    check("a5_before_start", 32'(tx_serial), 32'd1);
    step(1'b0, 8'h00);
    check("a5_start_bit", 32'(tx_serial), 32'd0);
    drain("a5_drain");

    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    check("burst_ready_full", 32'(tx_ready), 32'd0);
    drain("burst_drain");

    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    for (int n = 0; n < 100 && pos != 4 * C + 1; n++) step(1'b0, 8'h00);
    check("rst_reached_bit3", 32'(pos), 32'(4 * C + 1));
    check("rst_pre_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_serial_now", 32'(tx_serial),  32'd1);
    check("rst_count_now",  32'(fifo_count), 32'd0);
    check("rst_active_now", 32'(tx_active),  32'd0);
    check("rst_done_now",   32'(tx_done),    32'd0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    step(1'b1, 8'h3C);
    drain("post_rst_drain");

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i));
    check("full_before_pop", 32'(fifo_count), 32'd4);
    for (int n = 0; n < 100 && pos != -1; n++) step(1'b1, 8'($urandom));
    check("full_idle_reached", 32'(pos), 32'hFFFF_FFFF);
    step(1'b1, 8'hE1);
    check("pop_write_dropped", 32'(fifo_count), 32'd3);
    step(1'b1, 8'hE2);
    check("next_write_taken", 32'(fifo_count), 32'd4);
    drain("collision_drain");

    repeat (3000) step(($urandom % 4) == 0, 8'($urandom));
    drain("random_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
